// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//
// Shares one byte serializer among NREQ requesters. A round-robin search
// picks an owner in IDLE. The owner's byte is offered in SEND, and WAIT
// holds off the next byte until the serializer reports the end of the frame.
// A requester may keep the bus for up to MAXBURST consecutive frames by
// leaving req_last low.
//
// Handshake: a byte moves to the serializer on any cycle where tx_valid and
// tx_ready are both high. tx_valid never drops while a byte is pending. The
// owning requester sees a one-cycle gnt pulse in that same cycle. It must
// hold req/req_data/req_last stable until it sees that pulse.
//
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   req, req_last    per-requester request level / end-of-burst flag
//   req_data         requester i byte at [i*NBITS +: NBITS]
//   gnt              one-hot acceptance pulse to the owner
//   tx_data/valid    byte offered to the serializer
//   tx_ready         serializer can take a byte
//   tx_done          one-cycle end-of-frame pulse from the serializer
//   busy             arbiter is in SEND or WAIT
//   owner            current or last owner index
//   locked           owner holds the bus for a continuing burst
//   dbg_state_o      FSM state (0 IDLE, 1 SEND, 2 WAIT)
module serial_tx_arbiter #(
  parameter int NBITS    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*NBITS-1:0]    req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NBITS-1:0]         tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic                     tx_done,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     locked,
  output logic [1:0]               dbg_state_o
);

  localparam int OW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_owner_q, last_owner_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic            lock_q, lock_d;

  logic [OW-1:0]   winner;
  logic            win_found;
  logic            handshake;
  logic            lock_next;

  // Round-robin search: start one past the last owner and wrap modulo NREQ.
  // The explicit subtraction keeps the wrap correct when NREQ is not a power
  // of two.
  always_comb begin
    int            idx;
    logic [OW-1:0] sel;
    winner    = '0;
    win_found = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_owner_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = OW'(idx);
      if (!win_found && req[sel]) begin
        winner    = sel;
        win_found = 1'b1;
      end
    end
  end

  // The handshake is gated by rstn, so a reset cycle never issues a grant.
  assign handshake = (state_q == ST_SEND) && tx_ready && rstn;
  // beats_q counts frames already sent in this burst. The frame being
  // accepted now is number beats_q+1.
  assign lock_next = !req_last[owner_q] && ((int'(beats_q) + 1) < MAXBURST);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beats_d      = beats_q;
    lock_d       = lock_q;
    case (state_q)
      ST_IDLE: begin
        lock_d = 1'b0;
        if (win_found) begin
          owner_d      = winner;
          last_owner_d = winner;
          beats_d      = '0;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (handshake) begin
          beats_d = (beats_q == BW'(MAXBURST)) ? beats_q : beats_q + BW'(1);
          lock_d  = lock_next;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (lock_q && req[owner_q]) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
            lock_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        lock_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NREQ - 1);
      beats_q      <= '0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beats_q      <= beats_d;
      lock_q       <= lock_d;
    end
  end

  assign tx_valid    = (state_q == ST_SEND);
  assign tx_data     = (state_q == ST_SEND) ? req_data[int'(owner_q)*NBITS +: NBITS] : '0;
  assign gnt         = handshake ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_q) : '0;
  assign busy        = (state_q != ST_IDLE);
  assign owner       = owner_q;
  assign locked      = lock_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: directed scenarios plus randomized request
// queues checked against a transaction-level model of arbitration order.
module tb_serial_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int NBITS    = 8;
  localparam int MAXBURST = 4;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  rstn;
  logic [NREQ-1:0]       req, req_last, gnt;
  logic [NREQ*NBITS-1:0] req_data;
  logic [NBITS-1:0]      tx_data;
  logic                  tx_valid, tx_ready, tx_done, busy, locked;
  logic [1:0]            owner;
  logic [1:0]            dbg_state;

  always #5 clk = ~clk;

  serial_tx_arbiter #(.NBITS(NBITS), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_last(req_last), .req_data(req_data),
    .gnt(gnt), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .busy(busy), .owner(owner), .locked(locked),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_pass = 0;

  // Per-requester pending bytes: {last, data}. A requester raises req while
  // its queue is non-empty and pops the head when it sees gnt.
  logic [NBITS:0] rq [NREQ][$];
  int left = 0;

  // Reference model: last arbitration winner, current burst owner, frames
  // in the burst so far, and whether the next frame continues the burst.
  int m_last  = NREQ - 1;
  int m_owner = 0;
  int m_beats = 0;
  bit m_cont  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit l);
    rq[r].push_back({l, d});
    left++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rstn = 1'b0; req = '0; req_last = '0; req_data = '0;
    tx_ready = 1'b0; tx_done = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_tx_valid", 32'(tx_valid),  32'd0);
    chk("rst_tx_data",  32'(tx_data),   32'd0);
    chk("rst_gnt",      32'(gnt),       32'd0);
    chk("rst_owner",    32'(owner),     32'd0);
    chk("rst_locked",   32'(locked),    32'd0);
    chk("rst_state",    32'(dbg_state), 32'd0);
    rstn = 1'b1;
    m_last = NREQ - 1;
    m_cont = 1'b0;
  endtask

  task automatic drive_from_queues();
    logic [NBITS:0] e;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        e = rq[i][0];
        req[i] = 1'b1;
        req_last[i] = e[NBITS];
        req_data[i*NBITS +: NBITS] = e[NBITS-1:0];
      end else begin
        req[i] = 1'b0;
        req_last[i] = 1'b0;
        req_data[i*NBITS +: NBITS] = '0;
      end
    end
  endtask

  // Drains all queued bytes through the DUT with a serializer stand-in that
  // pulses tx_done 1..6 cycles after each grant. Every grant is checked
  // against the model's prediction.
  task automatic run_engine(input bit rnd, input int budget);
    int cyc = 0;
    int done_cnt = 0;
    bit post_done = 1'b0;
    int exp;
    logic [NBITS:0] e;
    while ((left > 0 || done_cnt > 0 || post_done) && cyc < budget) begin
      tick();
      cyc++;
      if (post_done) begin
        // The cycle after tx_done: SEND if the burst continues, else IDLE.
        chk("after_done_busy",  32'(busy),     32'(m_cont));
        chk("after_done_valid", 32'(tx_valid), 32'(m_cont));
        post_done = 1'b0;
      end
      tx_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          tx_done = 1'b1;
          post_done = 1'b1;
        end
      end else if (rnd && $urandom_range(0, 7) == 0) begin
        tx_done = 1'b1;  // stray pulse outside WAIT, must be ignored
      end
      drive_from_queues();
      tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (gnt != '0) begin
        if (m_cont) begin
          exp = m_owner;
        end else begin
          exp = -1;
          for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last + k) % NREQ;
            if (exp < 0 && rq[c].size() > 0) exp = c;
          end
          m_beats = 0;
          if (exp >= 0) m_last = exp;
        end
        if (exp < 0) begin
          chk("spurious_gnt", 32'(gnt), 32'd0);
        end else begin
          e = rq[exp][0];
          chk("gnt",     32'(gnt),     32'(1 << exp));
          chk("tx_data", 32'(tx_data), 32'(e[NBITS-1:0]));
          chk("owner",   32'(owner),   32'(exp));
          chk("locked",  32'(locked),  32'(m_cont));
          void'(rq[exp].pop_front());
          left--;
          m_beats++;
          m_owner = exp;
          m_cont = !e[NBITS] && (m_beats < MAXBURST) && (rq[exp].size() > 0);
          done_cnt = $urandom_range(1, 6);
        end
      end
    end
    tx_done = 1'b0;
    chk("engine_drained", 32'(left), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    do_reset();

    // Lone requester 2: valid and grant one cycle after req.
    req = 4'b0100; req_last = 4'b0100; req_data = '0;
    req_data[2*NBITS +: NBITS] = 8'hA5; tx_ready = 1'b1;
    tick();
    #1;
    chk("r2_valid", 32'(tx_valid), 32'd1);
    chk("r2_gnt",   32'(gnt),      32'h4);
    chk("r2_data",  32'(tx_data),  32'hA5);
    chk("r2_busy",  32'(busy),     32'd1);
    req = '0; req_last = '0; req_data = '0;
    tick();
    #1;
    chk("r2_wait_valid", 32'(tx_valid), 32'd0);
    chk("r2_wait_data",  32'(tx_data),  32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    #1;
    chk("r2_busy_fall", 32'(busy), 32'd0);

    // Round robin over all four, requester 0 twice: 0,1,2,3,0.
    do_reset();
    push(0, 8'hA0, 1'b1); push(0, 8'hA1, 1'b1);
    push(1, 8'hB0, 1'b1); push(2, 8'hC0, 1'b1); push(3, 8'hD0, 1'b1);
    run_engine(1'b0, 500);

    // Requester 1 bursts three bytes while requester 0 waits.
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b1);
    push(0, 8'h44, 1'b1);
    run_engine(1'b0, 500);

    // Requester 3 never ends its burst: cut at MAXBURST, then requester 0.
    for (int j = 0; j < 6; j++) push(3, 8'(8'h30 + j), j == 5);
    push(0, 8'h55, 1'b1);
    run_engine(1'b0, 500);

    // Randomized rounds with stalls and stray tx_done pulses.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        int n;
        n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++) push(i, 8'($urandom), (j == n - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      run_engine(1'b1, 3000);
    end

    // tx_ready low for five SEND cycles.
    do_reset();
    req = 4'b0010; req_last = 4'b0010; req_data[1*NBITS +: NBITS] = 8'h5C;
    tx_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data",  32'(tx_data),  32'h5C);
      chk("stall_gnt",   32'(gnt),      32'd0);
      tick();
    end
    tx_ready = 1'b1;
    #1;
    chk("stall_release_gnt", 32'(gnt), 32'h2);
    req = '0; req_last = '0; req_data = '0;
    tick();
    tx_ready = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    #1;
    chk("stall_busy_fall", 32'(busy), 32'd0);

    // Reset pulse during WAIT, then a stray tx_done.
    do_reset();
    req = 4'b1010; req_last = 4'b1010; req_data = '0;
    req_data[1*NBITS +: NBITS] = 8'h61; req_data[3*NBITS +: NBITS] = 8'h63;
    tx_ready = 1'b1;
    tick();
    #1;
    chk("wr_first_gnt", 32'(gnt), 32'h2);
    tick();
    #1;
    chk("wr_wait_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("wr_rst_gnt", 32'(gnt), 32'd0);
    tick();
    rstn = 1'b1;
    #1;
    chk("wr_busy",  32'(busy),     32'd0);
    chk("wr_valid", 32'(tx_valid), 32'd0);
    chk("wr_owner", 32'(owner),    32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    #1;
    chk("wr_regrant_gnt",  32'(gnt),     32'h2);
    chk("wr_regrant_data", 32'(tx_data), 32'h61);
    chk("wr_regrant_own",  32'(owner),   32'd1);
    req = 4'b1000; req_last = 4'b1000;
    tick();
    #1;
    chk("wr_wait_valid", 32'(tx_valid), 32'd0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
